// File: rtl/axi4_wr_aux_responder.sv
// rtl/axi4_wr_aux_responder.sv - AXI4 slave write-channel responder, one burst at a time
//
// Purpose:
//   Accepts one AW request, publishes {id,addr,len} on an info stream to the
//   local sink, opens the W path, counts W beats against awlen and returns a
//   single B response carrying the latched ID. The response is SLVERR when
//   wlast arrives early or is missing on the final counted beat.
//
// Ports:
//   axi_aclk, axi_aresetn          clock, asynchronous active-low reset
//   axi_aw*                        AW channel (id, addr, len, valid/ready)
//   axi_wvalid, axi_wlast, wready  W channel control (data goes straight to sink)
//   axi_b*                         B channel (id, resp, valid/ready)
//   info_tdata/tvalid/tready       {id,addr,len} stream to the local sink
//   data_ready                     sink can take a W beat this cycle
//   stream_en                      W path open; sink takes wvalid & wready beats
module axi4_wr_aux_responder #(
  parameter int ASIZE  = 32,
  parameter int IDSIZE = 4,
  parameter int LSIZE  = 8
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [IDSIZE-1:0]             axi_awid,
  input  logic [ASIZE-1:0]              axi_awaddr,
  input  logic [LSIZE-1:0]              axi_awlen,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic                          axi_wvalid,
  input  logic                          axi_wlast,
  output logic                          axi_wready,
  output logic [IDSIZE-1:0]             axi_bid,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  output logic [IDSIZE+ASIZE+LSIZE-1:0] info_tdata,
  output logic                          info_tvalid,
  input  logic                          info_tready,
  input  logic                          data_ready,
  output logic                          stream_en
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INFO = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state;
  logic [IDSIZE-1:0] id_q;
  logic [LSIZE-1:0]  len_q;
  logic [LSIZE-1:0]  cnt;
  logic              err;

  logic aw_hs;
  logic info_hs;
  logic w_hs;
  logic b_hs;
  logic cnt_at_len;
  logic burst_end;

  assign axi_wready = stream_en & data_ready;

  assign aw_hs      = axi_awvalid & axi_awready;
  assign info_hs    = info_tvalid & info_tready;
  assign w_hs       = axi_wvalid & axi_wready;
  assign b_hs       = axi_bvalid & axi_bready;

  // Compared before the increment, so len = all-ones still ends cleanly
  // on the final beat without needing a wider counter.
  assign cnt_at_len = (cnt == len_q);
  assign burst_end  = w_hs & (axi_wlast | cnt_at_len);

  // The error flag is registered on the ending beat, so it is already
  // valid in the first RESP cycle and can drive bresp directly.
  assign axi_bresp  = {err, 1'b0};

  // Outputs are assigned alongside the state transition so they reflect
  // the next state and are valid in the first cycle of that state.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= IDLE;
      id_q        <= '0;
      len_q       <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      axi_awready <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bid     <= '0;
      info_tdata  <= '0;
      info_tvalid <= 1'b0;
      stream_en   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q        <= axi_awid;
            len_q       <= axi_awlen;
            cnt         <= '0;
            err         <= 1'b0;
            info_tdata  <= {axi_awid, axi_awaddr, axi_awlen};
            info_tvalid <= 1'b1;
            axi_awready <= 1'b0;
            state       <= INFO;
          end else begin
            axi_awready <= 1'b1;
          end
        end
        INFO: begin
          if (info_hs) begin
            info_tvalid <= 1'b0;
            stream_en   <= 1'b1;
            state       <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            cnt <= cnt + {{(LSIZE-1){1'b0}}, 1'b1};
          end
          if (burst_end) begin
            // Early wlast or missing wlast both flag SLVERR.
            err        <= axi_wlast ^ cnt_at_len;
            stream_en  <= 1'b0;
            axi_bvalid <= 1'b1;
            axi_bid    <= id_q;
            state      <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_wr_aux_responder.sv
// tb/tb_axi4_wr_aux_responder.sv - directed bench for axi4_wr_aux_responder
module tb_axi4_wr_aux_responder;

  localparam int ASIZE  = 32;
  localparam int IDSIZE = 4;
  localparam int LSIZE  = 8;
  localparam int TW     = IDSIZE + ASIZE + LSIZE;

  logic              clk;
  logic              rst_n;
  logic [IDSIZE-1:0] awid;
  logic [ASIZE-1:0]  awaddr;
  logic [LSIZE-1:0]  awlen;
  logic              awvalid;
  logic              awready;
  logic              wvalid;
  logic              wlast;
  logic              wready;
  logic [IDSIZE-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [TW-1:0]     info_tdata;
  logic              info_tvalid;
  logic              info_tready;
  logic              data_ready;
  logic              stream_en;

  logic              tog;
  logic              tog_mode;
  logic              dr_fixed;

  int vectors;
  int miscompares;

  int            beats_acc;
  int            info_cnt;
  int            b_cnt;
  logic [TW-1:0] info_seen;

  axi4_wr_aux_responder #(
    .ASIZE (ASIZE),
    .IDSIZE(IDSIZE),
    .LSIZE (LSIZE)
  ) dut (
    .axi_aclk   (clk),
    .axi_aresetn(rst_n),
    .axi_awid   (awid),
    .axi_awaddr (awaddr),
    .axi_awlen  (awlen),
    .axi_awvalid(awvalid),
    .axi_awready(awready),
    .axi_wvalid (wvalid),
    .axi_wlast  (wlast),
    .axi_wready (wready),
    .axi_bid    (bid),
    .axi_bresp  (bresp),
    .axi_bvalid (bvalid),
    .axi_bready (bready),
    .info_tdata (info_tdata),
    .info_tvalid(info_tvalid),
    .info_tready(info_tready),
    .data_ready (data_ready),
    .stream_en  (stream_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial tog = 1'b0;
  always @(posedge clk) tog <= ~tog;
  assign data_ready = tog_mode ? tog : dr_fixed;

  // Handshake observer: counts transfers on the pre-edge signal values.
  initial begin
    beats_acc = 0;
    info_cnt  = 0;
    b_cnt     = 0;
    info_seen = '0;
  end
  always @(posedge clk) begin
    if (rst_n) begin
      if (wvalid && wready) beats_acc <= beats_acc + 1;
      if (info_tvalid && info_tready) begin
        info_cnt  <= info_cnt + 1;
        info_seen <= info_tdata;
      end
      if (bvalid && bready) b_cnt <= b_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [IDSIZE-1:0] id, input logic [ASIZE-1:0] addr,
                         input logic [LSIZE-1:0] len);
    int n;
    awid    = id;
    awaddr  = addr;
    awlen   = len;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (!awready) begin
      miscompares++;
      $display("FAIL aw_timeout: awready=%0b required 1", awready);
    end
    tick();
    awvalid = 1'b0;
  endtask

  // Drives nbeats W beats; wlast is set on beat number wlast_at (0 = never).
  task automatic send_beats(input int nbeats, input int wlast_at);
    int n;
    for (int i = 1; i <= nbeats; i++) begin
      wvalid = 1'b1;
      wlast  = (i == wlast_at);
      n = 0;
      while (!wready && n < 40) begin
        tick();
        n++;
      end
      vectors++;
      if (!wready) begin
        miscompares++;
        $display("FAIL w_timeout beat %0d: wready=%0b required 1", i, wready);
      end
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic b_handshake();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({awready, bvalid, info_tvalid, stream_en, wready} !== 5'b0 ||
        bid !== '0 || bresp !== 2'b00 || info_tdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: aw=%0b bv=%0b iv=%0b se=%0b bid=%0h bresp=%0b td=%0h required all 0",
               awready, bvalid, info_tvalid, stream_en, bid, bresp, info_tdata);
    end
    rst_n = 1'b1;
    vectors++;
    if (awready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_awready_early: awready=%0b required 0", awready);
    end
    tick();
    vectors++;
    if (awready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_awready_rise: awready=%0b required 1", awready);
    end
  endtask

  task automatic test_basic();
    int b0, i0, bc0;
    b0 = beats_acc; i0 = info_cnt; bc0 = b_cnt;
    send_aw(4'd3, 32'h1000, 8'd3);
    send_beats(4, 4);
    vectors++;
    if (info_cnt - i0 !== 1 || info_seen !== {4'd3, 32'h0000_1000, 8'd3}) begin
      miscompares++;
      $display("FAIL basic_info: count=%0d data=%0h required 1 and %0h",
               info_cnt - i0, info_seen, {4'd3, 32'h0000_1000, 8'd3});
    end
    vectors++;
    if (beats_acc - b0 !== 4) begin
      miscompares++;
      $display("FAIL basic_beats: %0d required 4", beats_acc - b0);
    end
    vectors++;
    if (bvalid !== 1'b1 || bid !== 4'd3 || bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_b: bvalid=%0b bid=%0d bresp=%0b required 1 3 00", bvalid, bid, bresp);
    end
    b_handshake();
    vectors++;
    if (b_cnt - bc0 !== 1) begin
      miscompares++;
      $display("FAIL basic_bcount: %0d required 1", b_cnt - bc0);
    end
  endtask

  task automatic test_len0();
    int b0, n;
    b0 = beats_acc;
    wvalid = 1'b1;
    wlast  = 1'b1;
    send_aw(4'd5, 32'h20, 8'd0);
    n = 0;
    while (!bvalid && n < 10) begin
      tick();
      n++;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    vectors++;
    if (n !== 2) begin
      miscompares++;
      $display("FAIL len0_turnaround: edges after AW=%0d required 2", n);
    end
    vectors++;
    if (beats_acc - b0 !== 1 || bresp !== 2'b00 || bid !== 4'd5) begin
      miscompares++;
      $display("FAIL len0_resp: beats=%0d bresp=%0b bid=%0d required 1 00 5", beats_acc - b0, bresp, bid);
    end
    vectors++;
    if (awready !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_awready_resp: awready=%0b required 0", awready);
    end
    b_handshake();
    vectors++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_awready_after_b: awready=%0b bvalid=%0b required 1 0", awready, bvalid);
    end
  endtask

  task automatic test_early_wlast();
    int b0;
    b0 = beats_acc;
    send_aw(4'd1, 32'h2000, 8'd3);
    send_beats(2, 2);
    wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wready !== 1'b0) begin
        miscompares++;
        $display("FAIL early_holdoff cycle %0d: wready=%0b required 0", i, wready);
      end
      tick();
    end
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b10 || bid !== 4'd1) begin
      miscompares++;
      $display("FAIL early_resp: bvalid=%0b bresp=%0b bid=%0d required 1 10 1", bvalid, bresp, bid);
    end
    b_handshake();
    wvalid = 1'b0;
    vectors++;
    if (beats_acc - b0 !== 2) begin
      miscompares++;
      $display("FAIL early_beats: %0d required 2", beats_acc - b0);
    end
  endtask

  task automatic test_missing_wlast();
    int b0;
    b0 = beats_acc;
    send_aw(4'd6, 32'h2400, 8'd1);
    send_beats(2, 0);
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b10 || bid !== 4'd6 || beats_acc - b0 !== 2) begin
      miscompares++;
      $display("FAIL missing_wlast: bvalid=%0b bresp=%0b bid=%0d beats=%0d required 1 10 6 2",
               bvalid, bresp, bid, beats_acc - b0);
    end
    b_handshake();
  endtask

  task automatic test_backpressure();
    int b0;
    b0 = beats_acc;
    info_tready = 1'b0;
    tog_mode    = 1'b1;
    send_aw(4'd7, 32'h000A_BCD0, 8'd2);
    wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (info_tvalid !== 1'b1 || wready !== 1'b0 || beats_acc != b0) begin
        miscompares++;
        $display("FAIL bp_info_wait cycle %0d: tvalid=%0b wready=%0b beats=%0d required 1 0 0",
                 i, info_tvalid, wready, beats_acc - b0);
      end
      tick();
    end
    info_tready = 1'b1;
    send_beats(3, 3);
    vectors++;
    if (info_seen !== {4'd7, 32'h000A_BCD0, 8'd2} || beats_acc - b0 !== 3) begin
      miscompares++;
      $display("FAIL bp_info_beats: data=%0h beats=%0d required %0h 3",
               info_seen, beats_acc - b0, {4'd7, 32'h000A_BCD0, 8'd2});
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bvalid !== 1'b1 || bid !== 4'd7 || bresp !== 2'b00) begin
        miscompares++;
        $display("FAIL bp_b_hold cycle %0d: bvalid=%0b bid=%0d bresp=%0b required 1 7 00",
                 i, bvalid, bid, bresp);
      end
      tick();
    end
    b_handshake();
    tog_mode = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int bc0;
    send_aw(4'd2, 32'h3000, 8'd3);
    send_beats(2, 0);
    bc0 = b_cnt;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({awready, bvalid, info_tvalid, stream_en, wready} !== 5'b0 ||
        bid !== '0 || bresp !== 2'b00 || info_tdata !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs: aw=%0b bv=%0b iv=%0b se=%0b wr=%0b bid=%0h bresp=%0b td=%0h required all 0",
               awready, bvalid, info_tvalid, stream_en, wready, bid, bresp, info_tdata);
    end
    bready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    bready = 1'b0;
    vectors++;
    if (b_cnt !== bc0 || bvalid !== 1'b0 || awready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_no_b: bcount=%0d bvalid=%0b awready=%0b required 0 0 1",
               b_cnt - bc0, bvalid, awready);
    end
    send_aw(4'd9, 32'h4000, 8'd1);
    send_beats(2, 2);
    vectors++;
    if (bvalid !== 1'b1 || bid !== 4'd9 || bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_next: bvalid=%0b bid=%0d bresp=%0b required 1 9 00", bvalid, bid, bresp);
    end
    b_handshake();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    awid        = '0;
    awaddr      = '0;
    awlen       = '0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    bready      = 1'b0;
    info_tready = 1'b1;
    dr_fixed    = 1'b1;
    tog_mode    = 1'b0;

    test_reset();
    test_basic();
    test_len0();
    test_early_wlast();
    test_missing_wlast();
    test_backpressure();
    test_reset_mid_burst();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
